// File: rtl/sr_frame_ctrl.sv
// sr_frame_ctrl: full-duplex serial frame controller.
// Accepts a parallel word over valid/ready, shifts it out MSB first while
// capturing the same number of serial input bits, pulses rx_valid_o when the
// received word is ready, then holds frame_o low for GAP idle cycles.
module sr_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             x_i,
  output logic             ser_o,
  output logic             frame_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // With GAP==0 the GAP state is unreachable, so the wrapped value is harmless.
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [GW-1:0] GAP_PRE  = GW'(GAP - 2);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [GW-1:0]    gap_cnt_r;
  // The shadow is zero-filled as it shifts, so its MSB is 0 outside SHIFT and
  // can drive ser_o directly.
  logic [WIDTH-1:0] shadow_r;
  // Only the low WIDTH-1 received bits need storing; the newest bit arrives
  // on x_i in the same cycle the word completes.
  logic [WIDTH-2:0] rx_sr_r;
  logic [WIDTH-1:0] rx_data_r;
  logic             rx_valid_r;
  logic             frame_r;
  logic             busy_r;
  logic             tx_ready_r;

  logic             accept_s;
  logic [WIDTH-1:0] rx_next_s;

  assign accept_s  = tx_valid_i & tx_ready_r;
  assign rx_next_s = {rx_sr_r, x_i};

  assign tx_ready_o = tx_ready_r;
  assign ser_o      = shadow_r[WIDTH-1];
  assign frame_o    = frame_r;
  assign rx_data_o  = rx_data_r;
  assign rx_valid_o = rx_valid_r;
  assign busy_o     = busy_r;

  // Frame sequencer: state, counters, shift registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      gap_cnt_r  <= '0;
      shadow_r   <= '0;
      rx_sr_r    <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      frame_r    <= 1'b0;
      busy_r     <= 1'b0;
      tx_ready_r <= 1'b1;
    end else begin
      rx_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            shadow_r   <= tx_data_i;
            cnt_r      <= '0;
            state_r    <= ST_SHIFT;
            frame_r    <= 1'b1;
            busy_r     <= 1'b1;
            tx_ready_r <= 1'b0;
          end else begin
            state_r    <= ST_IDLE;
            frame_r    <= 1'b0;
            busy_r     <= 1'b0;
            tx_ready_r <= 1'b1;
          end
        end

        ST_SHIFT: begin
          rx_sr_r <= rx_next_s[WIDTH-2:0];
          if (cnt_r == CNT_LAST) begin
            cnt_r      <= '0;
            rx_data_r  <= rx_next_s;
            rx_valid_r <= 1'b1;
            if (GAP > 0) begin
              shadow_r   <= {shadow_r[WIDTH-2:0], 1'b0};
              gap_cnt_r  <= '0;
              state_r    <= ST_GAP;
              frame_r    <= 1'b0;
              busy_r     <= 1'b1;
              tx_ready_r <= (GAP == 1);
            end else if (accept_s) begin
              shadow_r   <= tx_data_i;
              state_r    <= ST_SHIFT;
              frame_r    <= 1'b1;
              busy_r     <= 1'b1;
              tx_ready_r <= 1'b0;
            end else begin
              shadow_r   <= {shadow_r[WIDTH-2:0], 1'b0};
              state_r    <= ST_IDLE;
              frame_r    <= 1'b0;
              busy_r     <= 1'b0;
              tx_ready_r <= 1'b1;
            end
          end else begin
            cnt_r      <= cnt_r + CNT_ONE;
            shadow_r   <= {shadow_r[WIDTH-2:0], 1'b0};
            frame_r    <= 1'b1;
            busy_r     <= 1'b1;
            // Back-to-back frames without a gap accept during the last bit.
            tx_ready_r <= (GAP == 0) && (cnt_r == CNT_PRE);
          end
        end

        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r <= '0;
            if (accept_s) begin
              shadow_r   <= tx_data_i;
              cnt_r      <= '0;
              state_r    <= ST_SHIFT;
              frame_r    <= 1'b1;
              busy_r     <= 1'b1;
              tx_ready_r <= 1'b0;
            end else begin
              state_r    <= ST_IDLE;
              frame_r    <= 1'b0;
              busy_r     <= 1'b0;
              tx_ready_r <= 1'b1;
            end
          end else begin
            gap_cnt_r  <= gap_cnt_r + GAP_ONE;
            frame_r    <= 1'b0;
            busy_r     <= 1'b1;
            tx_ready_r <= (gap_cnt_r == GAP_PRE);
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          cnt_r      <= '0;
          gap_cnt_r  <= '0;
          shadow_r   <= '0;
          frame_r    <= 1'b0;
          busy_r     <= 1'b0;
          tx_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule
